// File: rtl/asi_spram.sv
// asi_spram: byte-lane single-port RAM behind the AXI slave RAM port.
// Fixed SLV_WS read latency, sticky out-of-range flag, saturating counters.
module asi_spram #(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 32,
  parameter int AXI_WSTRBW = AXI_DW / 8,
  parameter int RAM_DEPTH  = 1024,
  parameter int SLV_WS     = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  RAM_CLK,
  input  logic                  RAM_RESET,
  input  logic                  RAM_CEN,
  input  logic [AXI_WSTRBW-1:0] RAM_WEN,
  input  logic [AXI_AW-1:0]     RAM_A,
  input  logic [AXI_DW-1:0]     RAM_D,
  output logic [AXI_DW-1:0]     RAM_Q,
  output logic                  RAM_QV,
  output logic                  RAM_OOR,
  input  logic                  RAM_OOR_CLR,
  output logic [CNT_W-1:0]      RAM_RD_CNT,
  output logic [CNT_W-1:0]      RAM_WR_CNT
);

  localparam int OFS =
    (AXI_WSTRBW > 1) ? $clog2(AXI_WSTRBW) : 0;
  localparam int IW =
    (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [AXI_AW:0] DEPTH =
    (AXI_AW + 1)'(RAM_DEPTH);
  localparam int L = SLV_WS - 1;

  generate
    if ((AXI_DW % 8) != 0 || AXI_DW < 8)
    begin : g_bad_dw
      $error("asi_spram: AXI_DW must be a multiple of 8");
    end
    if (AXI_WSTRBW != AXI_DW / 8) begin : g_bad_strb
      $error("asi_spram: AXI_WSTRBW must be AXI_DW/8");
    end
    if (SLV_WS < 1 || SLV_WS > 8) begin : g_bad_ws
      $error("asi_spram: SLV_WS must be 1..8");
    end
    if (RAM_DEPTH < 1) begin : g_bad_depth
      $error("asi_spram: RAM_DEPTH must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
      $error("asi_spram: CNT_W must be >= 1");
    end
    if (AXI_AW < IW + OFS) begin : g_bad_aw
      $error("asi_spram: AXI_AW too narrow for RAM_DEPTH");
    end
  endgenerate

  logic [AXI_DW-1:0] mem [RAM_DEPTH];

  logic [AXI_AW-1:0] idx;
  logic [IW-1:0]     widx;
  logic              in_range;
  logic              acc;
  logic              rd;
  logic              wr;
  logic [AXI_DW-1:0] rd_word;

  logic [SLV_WS-1:0] pv;
  logic [AXI_DW-1:0] pd [SLV_WS];
  logic [SLV_WS-1:0] nv;
  logic [AXI_DW-1:0] nd [SLV_WS];

  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic              oor;

  assign idx      = RAM_A >> OFS;
  assign widx     = idx[IW-1:0];
  assign in_range = {1'b0, idx} < DEPTH;
  assign acc      = ~RAM_CEN;
  assign rd       = acc & (&RAM_WEN);
  assign wr       = acc & ~(&RAM_WEN);
  assign rd_word  = in_range ? mem[widx] : '0;

  // Byte-lane write; contents deliberately survive reset.
  always_ff @(posedge RAM_CLK) begin
    if (!RAM_RESET && wr && in_range) begin
      for (int b = 0; b < AXI_WSTRBW; b++) begin
        if (!RAM_WEN[b]) begin
          mem[widx][8*b +: 8] <= RAM_D[8*b +: 8];
        end
      end
    end
  end

  // Next-state view of each pipeline stage.
  always_comb begin
    nv    = '0;
    nv[0] = rd;
    nd[0] = rd_word;
    for (int i = 1; i < SLV_WS; i++) begin
      nv[i] = pv[i-1];
      nd[i] = pd[i-1];
    end
  end

  // Read pipeline; last stage also holds RAM_Q.
  always_ff @(posedge RAM_CLK) begin
    if (RAM_RESET) begin
      pv <= '0;
      for (int i = 0; i < SLV_WS; i++) begin
        pd[i] <= '0;
      end
    end else begin
      pv <= nv;
      for (int i = 0; i < SLV_WS; i++) begin
        if (nv[i]) begin
          pd[i] <= nd[i];
        end
      end
    end
  end

  // Saturating counters; reads count as they complete.
  always_ff @(posedge RAM_CLK) begin
    if (RAM_RESET) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (nv[L] && !(&rd_cnt)) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
      if (wr && !(&wr_cnt)) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
    end
  end

  // Sticky out-of-range flag; a new set beats clear.
  always_ff @(posedge RAM_CLK) begin
    if (RAM_RESET) begin
      oor <= 1'b0;
    end else if (acc && !in_range) begin
      oor <= 1'b1;
    end else if (RAM_OOR_CLR) begin
      oor <= 1'b0;
    end
  end

  assign RAM_Q      = pd[L];
  assign RAM_QV     = pv[L];
  assign RAM_OOR    = oor;
  assign RAM_RD_CNT = rd_cnt;
  assign RAM_WR_CNT = wr_cnt;

endmodule

// File: tb/tb_asi_spram.sv
// tb_asi_spram: three latencies driven in lockstep,
// checked against a read-history reference model.
module tb_asi_spram;

  logic         clk = 1'b0;
  logic         rst;
  logic         cen;
  logic [15:0]  wen;
  logic [31:0]  a;
  logic [127:0] d;
  logic         clr;

  logic [127:0] q1, q3, q8;
  logic         qv1, qv3, qv8;
  logic         oo1, oo3, oo8;
  logic [31:0]  rc1, wc1, rc8, wc8;
  logic [3:0]   rc3, wc3;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  int WS [3] = '{1, 3, 8};
  int CW [3] = '{32, 4, 32};

  localparam logic [127:0] PAT1 =
    128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] PAT2 =
    128'h00112233_44556677_8899AABB_CCDDEEEE;

  always #5 clk = ~clk;

  asi_spram #(.SLV_WS(1), .CNT_W(32)) u1 (
    .RAM_CLK(clk), .RAM_RESET(rst), .RAM_CEN(cen),
    .RAM_WEN(wen), .RAM_A(a), .RAM_D(d),
    .RAM_Q(q1), .RAM_QV(qv1), .RAM_OOR(oo1),
    .RAM_OOR_CLR(clr),
    .RAM_RD_CNT(rc1), .RAM_WR_CNT(wc1));

  asi_spram #(.SLV_WS(3), .CNT_W(4)) u3 (
    .RAM_CLK(clk), .RAM_RESET(rst), .RAM_CEN(cen),
    .RAM_WEN(wen), .RAM_A(a), .RAM_D(d),
    .RAM_Q(q3), .RAM_QV(qv3), .RAM_OOR(oo3),
    .RAM_OOR_CLR(clr),
    .RAM_RD_CNT(rc3), .RAM_WR_CNT(wc3));

  asi_spram #(.SLV_WS(8), .CNT_W(32)) u8 (
    .RAM_CLK(clk), .RAM_RESET(rst), .RAM_CEN(cen),
    .RAM_WEN(wen), .RAM_A(a), .RAM_D(d),
    .RAM_Q(q8), .RAM_QV(qv8), .RAM_OOR(oo8),
    .RAM_OOR_CLR(clr),
    .RAM_RD_CNT(rc8), .RAM_WR_CNT(wc8));

  function automatic logic [127:0] dq(int k);
    return (k == 0) ? q1 : (k == 1) ? q3 : q8;
  endfunction
  function automatic logic dqv(int k);
    return (k == 0) ? qv1 : (k == 1) ? qv3 : qv8;
  endfunction
  function automatic logic doo(int k);
    return (k == 0) ? oo1 : (k == 1) ? oo3 : oo8;
  endfunction
  function automatic logic [31:0] drc(int k);
    return (k == 0) ? rc1 : (k == 1) ? {28'b0, rc3} : rc8;
  endfunction
  function automatic logic [31:0] dwc(int k);
    return (k == 0) ? wc1 : (k == 1) ? {28'b0, wc3} : wc8;
  endfunction

  // Reference model: memory, read history by cycle.
  logic [127:0] mm [1024];
  logic         hv [16];
  int           hc [16];
  logic [127:0] hd [16];
  int           cyc = 0;
  int           last_rst = 0;
  logic [127:0] eq  [3];
  logic         eqv [3];
  logic         eoo [3];
  longint       erc [3];
  longint       ewc [3];

  int     m_idx, m_iss, m_s;
  logic   m_acc, m_rd, m_wr, m_inr;

  function automatic longint mx(int k);
    return (64'd1 << CW[k]) - 1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      last_rst = cyc;
      hv[cyc & 15] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        eq[k] = '0; eqv[k] = 1'b0; eoo[k] = 1'b0;
        erc[k] = 0; ewc[k] = 0;
      end
    end else begin
      m_acc = !cen;
      m_rd  = m_acc && (wen == 16'hFFFF);
      m_wr  = m_acc && (wen != 16'hFFFF);
      m_idx = int'(a / 16);
      m_inr = (a / 16) < 1024;
      hv[cyc & 15] = m_rd;
      hc[cyc & 15] = cyc;
      hd[cyc & 15] = m_inr ? mm[m_idx[9:0]] : '0;
      if (m_wr && m_inr) begin
        for (int b = 0; b < 16; b++) begin
          if (!wen[b]) mm[m_idx[9:0]][8*b +: 8] = d[8*b +: 8];
        end
      end
      for (int k = 0; k < 3; k++) begin
        m_iss  = cyc - WS[k] + 1;
        m_s    = m_iss & 15;
        eqv[k] = m_iss > last_rst && hv[m_s] &&
                 hc[m_s] == m_iss;
        if (eqv[k]) begin
          eq[k] = hd[m_s];
          if (erc[k] < mx(k)) erc[k]++;
        end
        if (m_wr && ewc[k] < mx(k)) ewc[k]++;
        if (m_acc && !m_inr) eoo[k] = 1'b1;
        else if (clr) eoo[k] = 1'b0;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison of every DUT against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("m%0d_qv", k), 128'(dqv(k)), 128'(eqv[k]));
        chk($sformatf("m%0d_q", k), dq(k), eq[k]);
        chk($sformatf("m%0d_oor", k), 128'(doo(k)), 128'(eoo[k]));
        chk($sformatf("m%0d_rc", k), 128'(drc(k)), 128'(erc[k]));
        chk($sformatf("m%0d_wc", k), 128'(dwc(k)), 128'(ewc[k]));
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step(input logic c, input logic [15:0] w,
                      input logic [31:0] ad,
                      input logic [127:0] dd);
    cen = c; wen = w; a = ad; d = dd;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b1, 16'($urandom), $urandom, rnd128());
  endtask

  task automatic rdi(input int i);
    step(1'b0, 16'hFFFF, (32'(i) << 4) | 32'($urandom_range(0, 15)),
         rnd128());
  endtask

  task automatic wri(input int i, input logic [15:0] w,
                     input logic [127:0] dd);
    step(1'b0, w, 32'(i) << 4, dd);
  endtask

  function automatic logic [15:0] rwen();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == 16'hFFFF) w[$urandom_range(0, 15)] = 1'b0;
    return w;
  endfunction

  int first [3];
  int cnt   [3];
  bit want;
  int r;

  initial begin
    rst = 1'b1; clr = 1'b0; cen = 1'b1;
    wen = '1; a = '0; d = '0;
    @(negedge clk);
    cmp_on = 1'b1;
    idle();
    rst = 1'b0;
    chk("rst_q", q1, '0);
    chk("rst_qv", 128'(qv8), '0);
    chk("rst_oor", 128'(oo3), '0);
    chk("rst_rc", 128'(rc1), '0);
    chk("rst_wc", 128'(wc3), '0);

    for (int i = 0; i < 1024; i++) begin
      wri(i, 16'h0000, (i < 8) ? 128'(32'h10 + i) : rnd128());
    end
    rst = 1'b1; idle(); rst = 1'b0;

    wri(4, 16'h0000, PAT1);
    wri(4, 16'hFFFE, {120'hFF, 8'hEE});
    rdi(4);
    chk("t1_q", q1, PAT2);
    chk("t1_qv", 128'(qv1), 128'(1));
    chk("t1_wc", 128'(wc1), 128'(2));
    chk("t1_rc", 128'(rc1), 128'(1));
    repeat (8) idle();

    for (int k = 0; k < 3; k++) begin
      first[k] = -1; cnt[k] = 0;
    end
    for (int s = 0; s < 14; s++) begin
      if (s < 4) rdi(s);
      else idle();
      for (int k = 0; k < 3; k++) begin
        want = (s >= WS[k] - 1) && (s < WS[k] + 3);
        chk($sformatf("t2_qv%0d_s%0d", WS[k], s),
            128'(dqv(k)), 128'(want));
        if (dqv(k)) begin
          if (first[k] < 0) first[k] = s;
          cnt[k]++;
          if (want)
            chk($sformatf("t2_q%0d_s%0d", WS[k], s),
                dq(k), 128'(32'h10 + s - WS[k] + 1));
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t2_first%0d", WS[k]),
          128'(first[k]), 128'(WS[k] - 1));
      chk($sformatf("t2_cnt%0d", WS[k]), 128'(cnt[k]), 128'(4));
    end

    wri(1024, 16'h0000, rnd128());
    chk("t3_oor_wr", 128'(oo1), 128'(1));
    rdi(1024);
    chk("t3_oor_q", q1, '0);
    chk("t3_oor_qv", 128'(qv1), 128'(1));
    rdi(0);
    chk("t3_idx0", q1, 128'h10);
    clr = 1'b1;
    rdi(1025);
    chk("t3_setwins", 128'(oo1), 128'(1));
    idle();
    chk("t3_clr", 128'(oo1), 128'(0));
    clr = 1'b0;
    repeat (8) idle();

    rdi(5);
    rst = 1'b1; idle(); rst = 1'b0;
    for (int s = 0; s < 10; s++) begin
      idle();
      chk($sformatf("t4_noqv_s%0d", s), 128'(qv3), '0);
    end
    chk("t4_q", q3, '0);
    chk("t4_rc", 128'(rc3), '0);
    chk("t4_wc", 128'(wc3), '0);
    rdi(5);
    idle(); idle();
    chk("t4_d5", q3, 128'h15);
    chk("t4_d5v", 128'(qv3), 128'(1));
    repeat (6) idle();

    repeat (10) idle();
    chk("t5_q", q1, 128'h15);
    chk("t5_rc", 128'(rc1), 128'(1));
    chk("t5_wc", 128'(wc1), '0);
    step(1'b0, 16'hFFFF, 32'h4F, rnd128());
    chk("t5_alias", q1, PAT2);
    repeat (8) idle();

    for (int i = 0; i < 20; i++) begin
      wri($urandom_range(0, 1023), rwen(), rnd128());
    end
    chk("t6_sat3", 128'(wc3), 128'(4'hF));
    chk("t6_wc1", 128'(wc1), 128'(20));

    for (int i = 0; i < 3000; i++) begin
      r   = $urandom_range(0, 99);
      rst = (r == 0);
      clr = ($urandom_range(0, 9) == 0);
      if (r < 30) idle();
      else if (r < 65) rdi($urandom_range(0, 1099));
      else wri($urandom_range(0, 1099), rwen(), rnd128());
    end
    rst = 1'b0; clr = 1'b0;
    repeat (10) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
